// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter. It arbitrates two write-back requesters (ALU, multi-cycle unit)
// onto one registered write port, forwards same-cycle reads and counts committed writes.
// Ports: clk, rst (async, active-low), hold, req0_*/req1_* valid/addr/data/ready,
//        rf_we/rf_waddr/rf_wdata, raddr1/2, fwd_hit1/2, fwd_data1/2, wr_count.
// Config: define WBARB_ROUND_ROBIN_EN for round-robin conflicts (default: req0 has fixed priority).
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic        fwd_hit1,
    output logic        fwd_hit2,
    output logic [31:0] fwd_data1,
    output logic [31:0] fwd_data2,
    output logic [15:0] wr_count
);

    logic        last_grant;
    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!hold) begin
            if (req0_valid && req1_valid) begin
`ifdef WBARB_ROUND_ROBIN_EN
                // Whoever did not win last time wins the conflict.
                gnt0 = last_grant;
                gnt1 = ~last_grant;
`else
                gnt0 = 1'b1;
`endif
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;
    assign sel_addr   = gnt1 ? req1_addr : req0_addr;
    assign sel_data   = gnt1 ? req1_data : req0_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= 32'd0;
            wr_count   <= 16'd0;
            last_grant <= 1'b1;
        end else begin
            // x0 writes are accepted but never reach the port.
            rf_we <= accept && (sel_addr != 5'd0);
            if (accept) begin
                rf_waddr   <= sel_addr;
                rf_wdata   <= sel_data;
                last_grant <= gnt1;
            end
            // The register file commits at the end of each cycle where rf_we is high.
            if (rf_we) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    assign fwd_hit1  = rf_we && (raddr1 == rf_waddr) && (raddr1 != 5'd0);
    assign fwd_hit2  = rf_we && (raddr2 == rf_waddr) && (raddr2 != 5'd0);
    assign fwd_data1 = fwd_hit1 ? rf_wdata : 32'd0;
    assign fwd_data2 = fwd_hit2 ? rf_wdata : 32'd0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: a bench-side arbitration model predicts the grant,
// and a scoreboard queue holds the expected write-port state for the following cycle.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic [15:0] wr_count;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req0_valid(req0_valid), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .wr_count(wr_count)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } port_t;

    port_t       sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        m_lg;
    logic [15:0] m_cnt;
    port_t       m_port;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        port_t p;
        p.we = 1'b0;
        p.addr = 5'd0;
        p.data = 32'd0;
        sb.delete();
        sb.push_back(p);
        m_port = p;
        m_lg = 1'b1;
        m_cnt = 16'd0;
    endtask

    task automatic idle_inputs();
        hold = 1'b0;
        req0_valid = 1'b0;
        req0_addr = 5'd0;
        req0_data = 32'd0;
        req1_valid = 1'b0;
        req1_addr = 5'd0;
        req1_data = 32'd0;
        raddr1 = 5'd0;
        raddr2 = 5'd0;
    endtask

    // One cycle: drive at negedge, check 1 time unit later, model the posedge.
    task automatic step(input logic h,
                        input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] r1, input logic [4:0] r2);
        port_t cur;
        port_t nxt;
        logic  g0;
        logic  g1;
        logic  e1;
        logic  e2;
        @(negedge clk);
        hold = h;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        raddr1 = r1; raddr2 = r2;
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty got=0 exp=1");
            return;
        end
        cur = sb.pop_front();
        check("rf_we", {31'd0, rf_we}, {31'd0, cur.we});
        check("rf_waddr", {27'd0, rf_waddr}, {27'd0, cur.addr});
        check("rf_wdata", rf_wdata, cur.data);
        check("wr_count", {16'd0, wr_count}, {16'd0, m_cnt});
        e1 = cur.we && (r1 == cur.addr) && (r1 != 5'd0);
        e2 = cur.we && (r2 == cur.addr) && (r2 != 5'd0);
        check("fwd_hit1", {31'd0, fwd_hit1}, {31'd0, e1});
        check("fwd_hit2", {31'd0, fwd_hit2}, {31'd0, e2});
        check("fwd_data1", fwd_data1, e1 ? cur.data : 32'd0);
        check("fwd_data2", fwd_data2, e2 ? cur.data : 32'd0);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!h) begin
            if (v0 && v1) begin
`ifdef WBARB_ROUND_ROBIN_EN
                g1 = (m_lg == 1'b0);
                g0 = ~g1;
`else
                g0 = 1'b1;
`endif
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        check("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
        nxt = cur;
        nxt.we = 1'b0;
        if (g0 || g1) begin
            nxt.addr = g1 ? a1 : a0;
            nxt.data = g1 ? d1 : d0;
            nxt.we = (nxt.addr != 5'd0);
            m_lg = g1;
        end
        sb.push_back(nxt);
        m_port = nxt;
        if (cur.we) m_cnt = m_cnt + 16'd1;
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_wr_count", {16'd0, wr_count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset state, then a single req0 write to x5.
        idle_step();
        step(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        idle_step();
        idle_step();

        // Continuous contention on x3 / x4.
        repeat (4)
            step(1'b0, 1'b1, 5'd3, 32'hAAAA_0003, 1'b1, 5'd4, 32'hBBBB_0004, 5'd3, 5'd4);
        // Same target address from both requesters.
        repeat (2)
            step(1'b0, 1'b1, 5'd9, 32'h0000_0009, 1'b1, 5'd9, 32'h9999_0000, 5'd9, 5'd0);
        idle_step();

        // x0 write is accepted but produces no port write.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        idle_step();
        idle_step();

        // Hold freezes both requesters, grant resumes on release.
        repeat (2)
            step(1'b1, 1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd4, 32'h4444_4444, 5'd0, 5'd0);
        repeat (2)
            step(1'b0, 1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd4, 32'h4444_4444, 5'd0, 5'd0);
        idle_step();

        // Forwarding of a write to x7.
        step(1'b0, 1'b1, 5'd7, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);

        // Random traffic over a small address range.
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle_step();

        // Reset during a pending write drops rf_we at once.
        step(1'b0, 1'b1, 5'd2, 32'h2222_2222, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        @(posedge clk);
        #2;
        check("pre_rst_we", {31'd0, rf_we}, 32'd1);
        rst = 1'b0;
        #1;
        check("async_rst_we", {31'd0, rf_we}, 32'd0);
        check("async_rst_cnt", {16'd0, wr_count}, 32'd0);
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_step();

        // 65536 committed writes wrap the counter back to zero.
        for (int i = 0; i < 65536; i++)
            step(1'b0, 1'b1, 5'd1, i, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        idle_step();
        idle_step();
        check("wrap_count", {16'd0, wr_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
